// File: rtl/ctr_array_param.sv
`default_nettype none
// ============================================================================
// Module      : ctr_array_param
// Description : Per-set replacement counter array. One CTR_W-bit counter per
//               set is reloaded to max on fill (and on hit in LRU mode),
//               decremented with saturation at zero when another way fills
//               the same set, and cleared by a sequenced flush sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module ctr_array_param #(
  parameter int NUM_SETS = 4,
  parameter int IDX_W    = 2,
  parameter int CTR_W    = 3,
  parameter int LRU_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] index,
  input  logic             fill,
  input  logic             dec,
  input  logic             hit,
  input  logic             flush_req,
  output logic [CTR_W-1:0] ctr_out,
  output logic             ctr_zero,
  output logic             busy,
  output logic             flush_done
);

  localparam logic [CTR_W-1:0] C_CTR_MAX  = '1;
  localparam logic [IDX_W-1:0] C_LAST_PTR = IDX_W'(NUM_SETS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             flush_done_q, flush_done_d;
  logic [CTR_W-1:0] ctr_q [NUM_SETS];
  logic [CTR_W-1:0] ctr_d [NUM_SETS];
  logic             reload;

  // A hit only refreshes the counter when the array tracks recency (LRU).
  assign reload = fill | ((LRU_MODE != 0) & hit);

  // Flush sweep sequencer: walks ptr over every set once, then pulses done.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    busy_d       = busy_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          state_d = S_SWEEP;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SWEEP: begin
        if (ptr_q == C_LAST_PTR) begin
          state_d      = S_IDLE;
          ptr_d        = '0;
          busy_d       = 1'b0;
          flush_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Counter next-state: sweep clears ptr's set; otherwise only the addressed
  // set moves. Out-of-range indices match no set, so they update nothing.
  always_comb begin
    for (int i = 0; i < NUM_SETS; i++) begin
      ctr_d[i] = ctr_q[i];
      if (busy_q) begin
        if (ptr_q == IDX_W'(i)) begin
          ctr_d[i] = '0;
        end
      end else if (index == IDX_W'(i)) begin
        if (reload) begin
          ctr_d[i] = C_CTR_MAX;
        end else if (dec && (ctr_q[i] != '0)) begin
          ctr_d[i] = ctr_q[i] - CTR_W'(1);
        end
      end
    end
  end

  // State and counter registers; reset abandons any sweep in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) begin
        ctr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
      for (int i = 0; i < NUM_SETS; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  // Combinational read of the addressed counter; unmapped indices read 0.
  always_comb begin
    ctr_out = '0;
    for (int i = 0; i < NUM_SETS; i++) begin
      if (index == IDX_W'(i)) begin
        ctr_out = ctr_q[i];
      end
    end
  end

  assign ctr_zero   = (ctr_out == '0);
  assign busy       = busy_q;
  assign flush_done = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ctr_array_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctr_array_param
// Description : Scoreboard bench for ctr_array_param. Three instances: FIFO
//               mode (dut0), LRU mode (dut1), and a 6-set/4-bit array (dut2).
//               Stimulus pushes expected values; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctr_array_param;

  localparam int K_CTR  = 0;
  localparam int K_ZERO = 1;
  localparam int K_BUSY = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int    dut;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] a_idx;
  logic       a_fill, a_dec, a_hit, a_flush;
  logic [2:0] c_idx;
  logic       c_fill, c_dec, c_hit, c_flush;

  logic [2:0] o0_ctr, o1_ctr;
  logic [3:0] o2_ctr;
  logic       o0_zero, o0_busy, o0_done;
  logic       o1_zero, o1_busy, o1_done;
  logic       o2_zero, o2_busy, o2_done;

  always #5 clk = ~clk;

  ctr_array_param #(.NUM_SETS(4), .IDX_W(2), .CTR_W(3), .LRU_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .index(a_idx), .fill(a_fill), .dec(a_dec),
    .hit(a_hit), .flush_req(a_flush), .ctr_out(o0_ctr), .ctr_zero(o0_zero),
    .busy(o0_busy), .flush_done(o0_done));

  ctr_array_param #(.NUM_SETS(4), .IDX_W(2), .CTR_W(3), .LRU_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .index(a_idx), .fill(a_fill), .dec(a_dec),
    .hit(a_hit), .flush_req(a_flush), .ctr_out(o1_ctr), .ctr_zero(o1_zero),
    .busy(o1_busy), .flush_done(o1_done));

  ctr_array_param #(.NUM_SETS(6), .IDX_W(3), .CTR_W(4), .LRU_MODE(0)) dut2 (
    .clk(clk), .reset(reset), .index(c_idx), .fill(c_fill), .dec(c_dec),
    .hit(c_hit), .flush_req(c_flush), .ctr_out(o2_ctr), .ctr_zero(o2_zero),
    .busy(o2_busy), .flush_done(o2_done));

  task automatic expect_v(input int d, input int k, input int v, input string n);
    exp_t e;
    e.dut  = d;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  // Same expectation for both 4-set instances.
  task automatic expect_ab(input int k, input int v, input string n);
    expect_v(0, k, v, n);
    expect_v(1, k, v, n);
  endtask

  function automatic int obs(input int d, input int k);
    logic [3:0] c;
    logic       z, b, f;
    int         r;
    case (d)
      0:       begin c = {1'b0, o0_ctr}; z = o0_zero; b = o0_busy; f = o0_done; end
      1:       begin c = {1'b0, o1_ctr}; z = o1_zero; b = o1_busy; f = o1_done; end
      default: begin c = o2_ctr;         z = o2_zero; b = o2_busy; f = o2_done; end
    endcase
    case (k)
      K_CTR:   r = int'(c);
      K_ZERO:  r = int'(z);
      K_BUSY:  r = int'(b);
      default: r = int'(f);
    endcase
    return r;
  endfunction

  // Monitor: outputs settle after the negedge input changes, then drain queue.
  initial begin
    exp_t e;
    int   got;
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = obs(e.dut, e.kind);
        checks++;
        if (got != e.val) begin
          failures++;
          $display("FAIL %s dut%0d kind=%0d got=%0d exp=%0d t=%0t",
                   e.name, e.dut, e.kind, got, e.val, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int others[3];
    int v;
    others = '{0, 1, 3};
    reset  = 1'b1;
    a_idx = '0; a_fill = 0; a_dec = 0; a_hit = 0; a_flush = 0;
    c_idx = '0; c_fill = 0; c_dec = 0; c_hit = 0; c_flush = 0;

    // Reset state
    repeat (2) @(negedge clk);
    expect_ab(K_BUSY, 0, "rst_busy");
    expect_ab(K_DONE, 0, "rst_done");
    expect_ab(K_CTR, 0, "rst_ctr0");
    expect_v(2, K_ZERO, 1, "rst_zero");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      a_idx = 2'(i);
      expect_ab(K_CTR, 0, "rst_ctr");
    end

    // T1: fill set 2
    @(negedge clk); a_idx = 2'd2; a_fill = 1;
    @(negedge clk); a_fill = 0;
    expect_ab(K_CTR, 7, "t1_fill");
    expect_ab(K_ZERO, 0, "t1_zero");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); a_idx = 2'(others[i]);
      expect_ab(K_CTR, 0, "t1_other");
    end

    // T2: saturating decrement
    @(negedge clk); a_idx = 2'd2; a_dec = 1;
    expect_ab(K_CTR, 7, "t2_start");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v = (6 - k > 0) ? 6 - k : 0;
      expect_ab(K_CTR, v, "t2_dec");
      expect_ab(K_ZERO, (v == 0) ? 1 : 0, "t2_zero");
    end
    a_dec = 0;

    // T3: fill+dec priority and hit behaviour per mode
    @(negedge clk); a_idx = 2'd1; a_fill = 1;
    @(negedge clk); a_fill = 0; a_dec = 1;
    repeat (4) @(negedge clk);
    a_dec = 0;
    expect_ab(K_CTR, 3, "t3_pre");
    a_fill = 1; a_dec = 1;
    @(negedge clk); a_fill = 0; a_dec = 0;
    expect_ab(K_CTR, 7, "t3_fill_dec");
    a_dec = 1;
    repeat (4) @(negedge clk);
    a_dec = 0;
    expect_ab(K_CTR, 3, "t3_pre_hit");
    a_hit = 1;
    @(negedge clk); a_hit = 0;
    expect_v(0, K_CTR, 3, "t3_hit_fifo");
    expect_v(1, K_CTR, 7, "t3_hit_lru");

    // T4: flush sweep over all-7 counters
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a_idx = 2'(i); a_fill = 1;
    end
    @(negedge clk); a_fill = 0; a_flush = 1; a_idx = 2'd0;
    expect_ab(K_CTR, 7, "t4_pre");
    expect_ab(K_BUSY, 0, "t4_idle");
    @(negedge clk); a_flush = 0;
    expect_ab(K_BUSY, 1, "t4_busy_c1");
    expect_ab(K_CTR, 7, "t4_set0_pending");
    @(negedge clk); a_fill = 1; a_flush = 1;
    expect_ab(K_CTR, 0, "t4_clr0");
    expect_ab(K_BUSY, 1, "t4_busy_c2");
    @(negedge clk); a_fill = 0; a_flush = 0;
    expect_ab(K_CTR, 0, "t4_fill_ignored");
    expect_ab(K_BUSY, 1, "t4_busy_c3");
    @(negedge clk); a_idx = 2'd3;
    expect_ab(K_CTR, 7, "t4_set3_pending");
    expect_ab(K_BUSY, 1, "t4_busy_c4");
    expect_ab(K_DONE, 0, "t4_done_early");
    @(negedge clk);
    expect_ab(K_CTR, 0, "t4_clr3");
    expect_ab(K_BUSY, 0, "t4_busy_end");
    expect_ab(K_DONE, 1, "t4_done");
    @(negedge clk);
    expect_ab(K_DONE, 0, "t4_done_pulse");
    expect_ab(K_BUSY, 0, "t4_no_restart");
    @(negedge clk); a_idx = 2'd1;
    expect_ab(K_CTR, 0, "t4_clr1");
    @(negedge clk); a_idx = 2'd2;
    expect_ab(K_CTR, 0, "t4_clr2");

    // T5: reset in the second sweep cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a_idx = 2'(i); a_fill = 1;
    end
    @(negedge clk); a_fill = 0; a_flush = 1;
    @(negedge clk); a_flush = 0;
    expect_ab(K_BUSY, 1, "t5_busy");
    @(negedge clk); reset = 1'b1; a_idx = 2'd2;
    expect_ab(K_CTR, 0, "t5_rst_ctr");
    expect_ab(K_BUSY, 0, "t5_rst_busy");
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      expect_ab(K_DONE, 0, "t5_no_done");
      expect_ab(K_BUSY, 0, "t5_idle");
    end
    a_idx = 2'd3;
    expect_ab(K_CTR, 0, "t5_rst_ctr3");

    // T6: 6-set, 4-bit instance
    @(negedge clk); c_idx = 3'd5; c_fill = 1;
    @(negedge clk); c_fill = 0;
    expect_v(2, K_CTR, 15, "t6_fill5");
    expect_v(2, K_ZERO, 0, "t6_zero5");
    @(negedge clk); c_idx = 3'd7; c_fill = 1;
    expect_v(2, K_CTR, 0, "t6_oob_read");
    expect_v(2, K_ZERO, 1, "t6_oob_zero");
    @(negedge clk); c_fill = 0;
    expect_v(2, K_CTR, 0, "t6_oob_nowrite");
    @(negedge clk); c_idx = 3'd6;
    expect_v(2, K_CTR, 0, "t6_oob6");
    @(negedge clk); c_idx = 3'd5;
    expect_v(2, K_CTR, 15, "t6_no_alias");
    @(negedge clk); c_flush = 1;
    expect_v(2, K_BUSY, 0, "t6_idle");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); c_flush = 0;
      expect_v(2, K_BUSY, 1, "t6_busy");
      expect_v(2, K_DONE, 0, "t6_done_early");
    end
    @(negedge clk);
    expect_v(2, K_BUSY, 0, "t6_busy_end");
    expect_v(2, K_DONE, 1, "t6_done");
    expect_v(2, K_CTR, 0, "t6_clr5");

    @(negedge clk);
    #4;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
